// File: rtl/serial_ring_pkg.sv
// Shared constants and state encoding for the serial word ring feeder.
// Bit-phase geometry matches the 8-bit serial ring buffer.
package serial_ring_pkg;

    localparam int BITS_PER_WORD = 8;
    localparam int PHASE_W = 3;
    localparam logic [PHASE_W-1:0] PHASE_LAST = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        LOAD
    } state_e;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO; read data is valid whenever not empty.
// A push while full is refused even when a pop happens on the same edge.
module byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rptr_q];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        mem_d  = mem_q;
        if (do_push) begin
            mem_d[wptr_q] = din;
            wptr_d = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/serial_word_loader.sv
// Feeds queued bytes bit-serially (LSB first) into the serial word ring,
// one byte per 8-cycle word period over a WORD_COUNT-word load pass.
module serial_word_loader
    import serial_ring_pkg::*;
#(
    parameter int WORD_COUNT = 22,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          start,
    output logic                          write,
    output logic                          din,
    output logic [PHASE_W-1:0]            phase,
    output logic [$clog2(WORD_COUNT)-1:0] slot,
    output logic                          busy,
    output logic                          done,
    output logic                          underrun
);

    localparam int SLOT_W = $clog2(WORD_COUNT);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(WORD_COUNT - 1);

    state_e                   state_q, state_d;
    logic [PHASE_W-1:0]       phase_q, phase_d;
    logic [SLOT_W-1:0]        slot_q, slot_d;
    logic [BITS_PER_WORD-1:0] shreg_q, shreg_d;
    logic                     wr_act_q, wr_act_d;
    logic                     underrun_q, underrun_d;
    logic                     done_q, done_d;

    logic                     boundary;
    logic                     load_word;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [7:0]               fifo_dout;

    byte_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(8)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (in_valid),
        .din  (in_data),
        .pop  (fifo_pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign boundary = (phase_q == PHASE_LAST);

    always_comb begin
        phase_d    = phase_q + PHASE_W'(1);
        state_d    = state_q;
        slot_d     = slot_q;
        shreg_d    = shreg_q;
        wr_act_d   = wr_act_q;
        underrun_d = underrun_q;
        done_d     = 1'b0;
        load_word  = 1'b0;
        fifo_pop   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    underrun_d = 1'b0;
                    slot_d     = '0;
                    if (boundary) begin
                        state_d   = LOAD;
                        load_word = 1'b1;
                    end else begin
                        state_d = ARMED;
                    end
                end
            end
            ARMED: begin
                if (boundary) begin
                    state_d   = LOAD;
                    slot_d    = '0;
                    load_word = 1'b1;
                end
            end
            LOAD: begin
                if (boundary) begin
                    if (slot_q == SLOT_LAST) begin
                        state_d  = IDLE;
                        slot_d   = '0;
                        wr_act_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        slot_d    = slot_q + SLOT_W'(1);
                        load_word = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An empty FIFO leaves the word untouched so the ring recirculates it.
        if (load_word) begin
            if (!fifo_empty) begin
                fifo_pop = 1'b1;
                shreg_d  = fifo_dout;
                wr_act_d = 1'b1;
            end else begin
                wr_act_d   = 1'b0;
                underrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            slot_q     <= '0;
            shreg_q    <= '0;
            wr_act_q   <= 1'b0;
            underrun_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            slot_q     <= slot_d;
            shreg_q    <= shreg_d;
            wr_act_q   <= wr_act_d;
            underrun_q <= underrun_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = !fifo_full;
    assign write    = wr_act_q;
    assign din      = wr_act_q ? shreg_q[phase_q] : 1'b0;
    assign phase    = phase_q;
    assign slot     = slot_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_serial_word_loader.sv
// Scoreboard bench for serial_word_loader: a pass-window model predicts
// which queued bytes land in which word, a negedge monitor compares.
module tb_serial_word_loader;

    localparam int WC    = 22;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       start;
    logic       write;
    logic       din;
    logic [2:0] phase;
    logic [4:0] slot;
    logic       busy;
    logic       done;
    logic       underrun;

    always #5 clk = ~clk;

    serial_word_loader #(
        .WORD_COUNT(WC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .start   (start),
        .write   (write),
        .din     (din),
        .phase   (phase),
        .slot    (slot),
        .busy    (busy),
        .done    (done),
        .underrun(underrun)
    );

    typedef struct {
        logic [7:0] b;
        int         slot;
        int         st;
    } word_t;

    word_t      eq[$];
    logic [7:0] mq[$];
    int         cyc;
    int         m_b;
    int         done_cyc;
    bit         m_busy;
    bit         m_und;
    bit         mon_en;
    bit         full_b;
    int         k;
    word_t      w;
    int         words;
    int         n_tests;
    int         n_fail;

    function automatic void chk(string nm, logic [31:0] act, int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endfunction

    function automatic void timeout(string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout, got no event, expected one (cycle %0d)",
                 nm, cyc);
    endfunction

    // Reference model: pass window is computed arithmetically from the
    // cycle in which start was accepted; FIFO is a plain queue.
    initial begin
        cyc = 0; m_busy = 0; m_und = 0; done_cyc = -1; mon_en = 0;
        forever begin
            @(posedge clk);
            mon_en = 1;
            if (reset) begin
                cyc = 0; m_busy = 0; m_und = 0; done_cyc = -1;
                mq.delete();
                eq.delete();
            end else begin
                full_b = (mq.size() >= DEPTH);
                if (!m_busy && start) begin
                    m_busy = 1;
                    m_b    = cyc + (7 - cyc % 8);
                    m_und  = 0;
                end
                if (m_busy && cyc % 8 == 7 && cyc >= m_b) begin
                    k = (cyc - m_b) / 8;
                    if (k == WC) begin
                        m_busy   = 0;
                        done_cyc = cyc + 1;
                    end else if (mq.size() > 0) begin
                        w.b    = mq.pop_front();
                        w.slot = k;
                        w.st   = cyc + 1;
                        eq.push_back(w);
                    end else begin
                        m_und = 1;
                    end
                end
                if (in_valid && !full_b) mq.push_back(in_data);
                cyc++;
            end
        end
    end

    // Monitor: compares every visible output against the model each cycle.
    initial begin
        bit exp_wr;
        words = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("phase", phase, cyc % 8);
                exp_wr = (eq.size() > 0) && (eq[0].st <= cyc);
                chk("write", write, exp_wr);
                if (exp_wr) begin
                    chk("din", din, eq[0].b[cyc - eq[0].st]);
                    chk("word_slot", slot, eq[0].slot);
                    if (cyc == eq[0].st + 7) begin
                        void'(eq.pop_front());
                        words++;
                    end
                end else begin
                    chk("din_idle", din, 0);
                end
                chk("busy", busy, m_busy);
                chk("done", done, cyc == done_cyc);
                chk("underrun", underrun, m_und);
                chk("in_ready", in_ready, mq.size() < DEPTH);
                chk("slot", slot,
                    (m_busy && cyc > m_b) ? (cyc - m_b - 1) / 8 : 0);
            end
        end
    end

    task automatic wait_phase(input int p);
        for (int i = 0; i < 16; i++) begin
            if (phase == 3'(p)) return;
            @(negedge clk);
        end
        timeout("wait_phase");
    endtask

    task automatic wait_slot(input int s, input int p);
        for (int i = 0; i < 500; i++) begin
            if (busy && slot == 5'(s) && phase == 3'(p)) return;
            @(negedge clk);
        end
        timeout("wait_slot");
    endtask

    task automatic wait_idle(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (!busy) return;
            @(negedge clk);
        end
        timeout("wait_idle");
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bit acc;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            acc = in_ready;
            @(negedge clk);
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        timeout("push_byte");
    endtask

    task automatic push_stream(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            push_byte(8'($urandom));
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
        end
    endtask

    initial begin
        int w0;
        n_tests = 0; n_fail = 0;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; start = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_phase", phase, 0);
        chk("rst_ready", in_ready, 1);
        reset = 1'b0;

        // Single byte 0xA5 with a start at phase 3.
        w0 = words;
        push_byte(8'hA5);
        wait_phase(3);
        pulse_start();
        wait_idle(400);
        chk("single_words", words - w0, 1);
        chk("single_underrun", underrun, 1);
        repeat (4) @(negedge clk);

        // Backpressure: fifth byte held until the first pop, then full image.
        w0 = words;
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        in_data  = 8'h3C;
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_ready", in_ready, 0);
        fork
            begin
                push_byte(8'h3C);
                push_stream(17, 0);
            end
            begin
                wait_phase($urandom_range(0, 7));
                pulse_start();
            end
        join
        wait_idle(400);
        chk("full_words", words - w0, 22);
        chk("full_underrun", underrun, 0);
        repeat (3) @(negedge clk);

        // Start on a boundary edge; starts during LOAD and on the done edge.
        fork
            push_stream(10, 12);
            begin
                wait_phase(7);
                pulse_start();
                wait_slot(5, 2);
                pulse_start();
                wait_slot(21, 7);
                pulse_start();
            end
        join
        wait_idle(400);
        repeat (20) @(negedge clk);
        chk("no_second_pass", busy, 0);

        // Randomized passes.
        for (int r = 0; r < 3; r++) begin
            fork
                push_stream($urandom_range(0, 16), $urandom_range(0, 6));
                begin
                    repeat ($urandom_range(0, 9)) @(negedge clk);
                    pulse_start();
                    wait_idle(400);
                end
            join
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        // Reset mid-pass at slot 10, phase 4 with bytes still queued.
        for (int i = 0; i < 4; i++) push_byte(8'($urandom));
        fork
            push_stream(9, 0);
            begin
                wait_phase(2);
                pulse_start();
            end
        join
        wait_slot(10, 4);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_write", write, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", in_ready, 1);
        reset = 1'b0;
        w0 = words;
        pulse_start();
        wait_idle(400);
        chk("postrst_words", words - w0, 0);
        chk("postrst_underrun", underrun, 1);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", eq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
